// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of the CPU pipeline. Takes the ALU result as a byte
// address and runs a single load or store on a single-outstanding req/ack
// data bus. Handles byte, halfword and word sizing, lane replication for
// stores, and lane extraction with sign/zero extension for loads. It holds
// the upstream stages with `stall` while a transfer is in flight.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a cycle counter bounds the bus wait to TIMEOUT_CYCLES.
//   When the counter expires the transfer is abandoned and `bus_err` pulses.
//   When undefined, ACCESS waits for `bus_ack` indefinitely and `bus_err`
//   is tied to 0.
//
// Parameters
//   TIMEOUT_CYCLES  bus wait limit (1..255); used only with MEM_TIMEOUT_EN
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   memread        load instruction in stage
//   memwrite       store instruction in stage (wins over memread)
//   mem_size       00 byte, 01 half, 10/11 word
//   mem_unsigned   1 = zero-extend loads, 0 = sign-extend
//   alu_result     byte address
//   store_data     store operand
//   stall          hold upstream stages, inputs must stay stable
//   misaligned     one-cycle pulse, misaligned access dropped
//   bus_err        one-cycle pulse, bus timeout
//   mem_read_data  extended load result (registered)
//   bus_req        transfer request (registered)
//   bus_we         1 = write
//   bus_addr       word-aligned address
//   bus_be         byte enables (0 for loads)
//   bus_wdata      lane-replicated write data (0 for loads)
//   bus_ack        slave completion, one cycle per transfer
//   bus_rdata      read data, valid with bus_ack
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic [31:0] mem_read_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      state_q;

  // Access attributes latched when the transfer is launched, so the load
  // extraction does not depend on the (stalled) inputs during ACCESS.
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  addr_lo_q;
  logic        is_load_q;

  logic        misaligned_q;
  logic [31:0] mem_read_data_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;

  // Combinational next values for the bus lanes and the load result.
  logic        mem_op;
  logic        addr_aligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_data_d;
  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  timeout_cnt_q;
  logic        bus_err_q;
`endif

  assign mem_op = memread | memwrite;

  // Bytes are always aligned; halves need addr[0]=0; words (and size 11)
  // need addr[1:0]=0.
  always_comb begin
    addr_aligned = 1'b1;
    case (mem_size)
      2'b00:   addr_aligned = 1'b1;
      2'b01:   addr_aligned = ~alu_result[0];
      default: addr_aligned = (alu_result[1:0] == 2'b00);
    endcase
  end

  assign stall = ((state_q == ST_IDLE) & mem_op & addr_aligned) |
                 (state_q == ST_ACCESS);

  // Store lane placement: replicate the operand across every lane and let
  // the byte enables pick the active one(s).
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data;
    case (mem_size)
      2'b00: begin
        be_d    = 4'b0001 << alu_result[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_d    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data;
      end
    endcase
  end

  // Split the read bus into byte lanes for the extraction mux.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rd_byte[gi] = bus_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    sel_byte    = rd_byte[addr_lo_q];
    sel_half    = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_data_d = bus_rdata;
    case (size_q)
      2'b00:   load_data_d = unsigned_q ? {24'h000000, sel_byte}
                                        : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_data_d = unsigned_q ? {16'h0000, sel_half}
                                        : {{16{sel_half[15]}}, sel_half};
      default: load_data_d = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      size_q          <= 2'b00;
      unsigned_q      <= 1'b0;
      addr_lo_q       <= 2'b00;
      is_load_q       <= 1'b0;
      misaligned_q    <= 1'b0;
      mem_read_data_q <= 32'h0;
      bus_req_q       <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= 32'h0;
      bus_be_q        <= 4'h0;
      bus_wdata_q     <= 32'h0;
`ifdef MEM_TIMEOUT_EN
      timeout_cnt_q   <= 8'h0;
      bus_err_q       <= 1'b0;
`endif
    end else begin
      misaligned_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_q    <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (mem_op) begin
            if (addr_aligned) begin
              size_q      <= mem_size;
              unsigned_q  <= mem_unsigned;
              addr_lo_q   <= alu_result[1:0];
              is_load_q   <= ~memwrite;
              bus_req_q   <= 1'b1;
              bus_we_q    <= memwrite;
              bus_addr_q  <= {alu_result[31:2], 2'b00};
              bus_be_q    <= memwrite ? be_d : 4'h0;
              bus_wdata_q <= memwrite ? wdata_d : 32'h0;
`ifdef MEM_TIMEOUT_EN
              timeout_cnt_q <= 8'h0;
`endif
              state_q     <= ST_ACCESS;
            end else begin
              // Dropped without a bus cycle; a load returns 0.
              misaligned_q <= 1'b1;
              if (!memwrite) begin
                mem_read_data_q <= 32'h0;
              end
            end
          end
        end

        ST_ACCESS: begin
          if (bus_ack) begin
            if (is_load_q) begin
              mem_read_data_q <= load_data_d;
            end
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            state_q     <= ST_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_cnt_q == TIMEOUT_LAST) begin
            // This was the last allowed wait cycle: abandon the transfer.
            bus_err_q <= 1'b1;
            if (is_load_q) begin
              mem_read_data_q <= 32'h0;
            end
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            state_q     <= ST_DONE;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 8'd1;
          end
`endif
        end

        // One cycle for the pipeline to advance past this instruction;
        // its memory inputs are still present and must not relaunch.
        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign misaligned    = misaligned_q;
  assign mem_read_data = mem_read_data_q;
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;

`ifdef MEM_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule
